// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
//
// Programmable integer clock divider with glitch-free divisor changes.
//
// The counter runs 0 .. cur_div-1. clk_out is high for the first
// ceil(cur_div/2) counts of each period. A divisor change requested while
// running is held in nxt_div and only takes effect at a period boundary, so
// a period that is in progress never changes length.
//
// Optional feature macro: CLK_DIV_CTRL_ERR_EN
//   undefined : div_val < 2 is clamped to 2 and acknowledged normally
//   defined   : div_val < 2 is rejected, and err pulses for one cycle
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   run request; sampled at every period boundary
//   div_req  in   request to load div_val (pulse or level)
//   div_val  in   requested divisor, sampled when div_req=1 and busy=0
//   div_ack  out  1-cycle pulse in the first cycle the new divisor is used
//   busy     out  a divisor change is pending
//   clk_out  out  divided clock, straight from a flop
//   tick     out  high in the last cycle of every divided period
//   err      out  (CLK_DIV_CTRL_ERR_EN only) illegal divisor rejected
//
// Handshake: a request is taken in any cycle with div_req=1 and busy=0.
// Requests seen while busy=1 are dropped without any response. Each taken
// legal request produces exactly one div_ack.
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_req,
    input  logic [WIDTH-1:0] div_val,
    output logic             div_ack,
    output logic             busy,
    output logic             clk_out,
    output logic             tick
`ifdef CLK_DIV_CTRL_ERR_EN
    ,
    output logic             err
`endif
);

    localparam logic [WIDTH-1:0] RESET_DIV_W = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV     = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, PEND, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [WIDTH-1:0] nxt_div_q, nxt_div_d;
    // DRAIN alone does not say whether a change is still owed at the
    // boundary, so that fact is carried alongside it.
    logic             drain_pend_q, drain_pend_d;
    logic             clk_out_q, clk_out_d;
    logic             ack_q, ack_d;

    logic             pending;
    logic             wrap;
    logic             req_legal;
    logic             accept;
    logic             pend_new;
    logic [WIDTH-1:0] req_val;
    logic [WIDTH-1:0] half_d;

`ifdef CLK_DIV_CTRL_ERR_EN
    logic             reject;
    logic             err_q;
`endif

    assign pending = (state_q == PEND) || ((state_q == DRAIN) && drain_pend_q);
    assign wrap    = (state_q != IDLE) && (cnt_q == (cur_div_q - ONE));

    assign req_val = (div_val < MIN_DIV) ? MIN_DIV : div_val;
`ifdef CLK_DIV_CTRL_ERR_EN
    assign req_legal = (div_val >= MIN_DIV);
    assign reject    = div_req && !pending && !req_legal;
`else
    assign req_legal = 1'b1;
`endif
    assign accept = div_req && !pending && req_legal;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_div_d    = cur_div_q;
        nxt_div_d    = nxt_div_q;
        drain_pend_d = drain_pend_q;
        ack_d        = 1'b0;
        pend_new     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // A change and a start on the same edge: the new divisor is
                // loaded first, so the first period already uses it.
                if (accept) begin
                    cur_div_d = req_val;
                    ack_d     = 1'b1;
                end
                if (en) begin
                    state_d = RUN;
                end
            end
            default: begin
                if (wrap) begin
                    cnt_d        = '0;
                    drain_pend_d = 1'b0;
                    if (pending) begin
                        cur_div_d = nxt_div_q;
                        ack_d     = 1'b1;
                    end
                    if (en) begin
                        // A request taken in the tick cycle waits a full
                        // period: the boundary it arrived at is already
                        // committed to the old divisor.
                        state_d = accept ? PEND : RUN;
                        if (accept) begin
                            nxt_div_d = req_val;
                        end
                    end else begin
                        // Stopping: no further period to wait for, so a
                        // request taken now is applied on entry to IDLE.
                        state_d = IDLE;
                        if (accept) begin
                            cur_div_d = req_val;
                            ack_d     = 1'b1;
                        end
                    end
                end else begin
                    cnt_d    = cnt_q + ONE;
                    pend_new = pending || accept;
                    if (accept) begin
                        nxt_div_d = req_val;
                    end
                    if (en) begin
                        state_d = pend_new ? PEND : RUN;
                    end else begin
                        state_d      = DRAIN;
                        drain_pend_d = pend_new;
                    end
                end
            end
        endcase

        // clk_out is registered, so it is computed from the next count and
        // next divisor to line up with cnt in the following cycle.
        half_d    = (cur_div_d >> 1) + {{(WIDTH-1){1'b0}}, cur_div_d[0]};
        clk_out_d = (state_d != IDLE) && (cnt_d < half_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cur_div_q    <= RESET_DIV_W;
            nxt_div_q    <= RESET_DIV_W;
            drain_pend_q <= 1'b0;
            clk_out_q    <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_div_q    <= cur_div_d;
            nxt_div_q    <= nxt_div_d;
            drain_pend_q <= drain_pend_d;
            clk_out_q    <= clk_out_d;
            ack_q        <= ack_d;
        end
    end

`ifdef CLK_DIV_CTRL_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= reject;
        end
    end
    assign err = err_q;
`endif

    assign div_ack = ack_q;
    assign busy    = pending;
    assign clk_out = clk_out_q;
    assign tick    = wrap;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl
//
// Directed scenarios followed by a randomized run. A period-level reference
// model (counter position, active divisor, one optional owed change) predicts
// clk_out, tick, busy, div_ack (and err) for every cycle. Inputs change on
// the falling edge; outputs are compared on the falling edge after the
// model has absorbed the rising edge.
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             en = 1'b0;
    logic             div_req = 1'b0;
    logic [WIDTH-1:0] div_val = '0;
    logic             div_ack;
    logic             busy;
    logic             clk_out;
    logic             tick;
`ifdef CLK_DIV_CTRL_ERR_EN
    logic             err;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit m_active;
    int m_cnt;
    int m_div;
    bit m_pend;
    int m_nxt;
    bit m_ack;
    bit m_err;

    clk_div_ctrl #(.WIDTH(WIDTH), .RESET_DIV(7)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div_req (div_req),
        .div_val (div_val),
        .div_ack (div_ack),
        .busy    (busy),
        .clk_out (clk_out),
        .tick    (tick)
`ifdef CLK_DIV_CTRL_ERR_EN
        ,
        .err     (err)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string where);
        bit e_clk;
        bit e_tick;
        e_clk  = m_active && (m_cnt < (m_div + 1) / 2);
        e_tick = m_active && (m_cnt == m_div - 1);
        chk({where, ".clk_out"}, clk_out, e_clk);
        chk({where, ".tick"}, tick, e_tick);
        chk({where, ".busy"}, busy, m_pend);
        chk({where, ".div_ack"}, div_ack, m_ack);
`ifdef CLK_DIV_CTRL_ERR_EN
        chk({where, ".err"}, err, m_err);
`endif
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_active = 1'b0;
        m_cnt    = 0;
        m_div    = 7;
        m_pend   = 1'b0;
        m_nxt    = 7;
        m_ack    = 1'b0;
        m_err    = 1'b0;
    endtask

    // One rising edge with the inputs that were applied in the cycle before.
    task automatic model_step(input bit e, input bit r, input int v);
        bit legal;
        bit take;
        int val;
`ifdef CLK_DIV_CTRL_ERR_EN
        legal = (v >= 2);
`else
        legal = 1'b1;
`endif
        val   = (v < 2) ? 2 : v;
        take  = r && !m_pend && legal;
        m_err = r && !m_pend && !legal;
        m_ack = 1'b0;
        if (!m_active) begin
            if (take) begin
                m_div = val;
                m_ack = 1'b1;
            end
            if (e) begin
                m_active = 1'b1;
                m_cnt    = 0;
            end
        end else if (m_cnt == m_div - 1) begin
            // Period boundary: owed change lands, en decides whether to go on.
            m_cnt = 0;
            if (m_pend) begin
                m_div  = m_nxt;
                m_pend = 1'b0;
                m_ack  = 1'b1;
            end
            if (e) begin
                if (take) begin
                    m_nxt  = val;
                    m_pend = 1'b1;
                end
            end else begin
                m_active = 1'b0;
                if (take) begin
                    m_div = val;
                    m_ack = 1'b1;
                end
            end
        end else begin
            m_cnt = m_cnt + 1;
            if (take) begin
                m_nxt  = val;
                m_pend = 1'b1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit e, input bit r, input int v, input string tag);
        en      = e;
        div_req = r;
        div_val = WIDTH'(v);
        @(posedge clk);
        model_step(e, r, v);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic run(input int n, input bit e, input string tag);
        for (int k = 0; k < n; k++) begin
            cycle(e, 1'b0, 0, tag);
        end
    endtask

    // Runs until the model sits at count 'target' (bounded by the model).
    task automatic run_to(input int target, input string tag);
        int k;
        k = 0;
        while (!(m_active && m_cnt == target) && k < 300) begin
            cycle(1'b1, 1'b0, 0, tag);
            k++;
        end
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs({tag, ".async"});
        @(negedge clk);
        check_outputs({tag, ".held"});
        rst_n = 1'b1;
        en = 1'b0;
        div_req = 1'b0;
        #1;
        check_outputs({tag, ".released"});
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #1;
        rst_n = 1'b0;
        #11;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("after_reset");

        run(3, 1'b0, "idle");

        // Default N=7: 4 high / 3 low, tick on the last low cycle
        run(21, 1'b1, "n7_run");

        // Change to 4 at cnt=2, second request while busy is dropped
        run_to(2, "to_cnt2");
        cycle(1'b1, 1'b1, 4, "req4");
        cycle(1'b1, 1'b1, 9, "req9_busy");
        run(14, 1'b1, "n4_run");

        // N=5, stop at cnt=1, restart later
        cycle(1'b1, 1'b1, 5, "req5");
        run(12, 1'b1, "n5_run");
        run_to(1, "to_cnt1");
        run(10, 1'b0, "n5_drain");
        run(8, 1'b1, "n5_restart");

        // div_val=0
        cycle(1'b1, 1'b1, 0, "req0");
        run(12, 1'b1, "n0_run");

        // Request in the tick cycle waits one full period
        cycle(1'b1, 1'b1, 5, "req5b");
        run(8, 1'b1, "n5b_run");
        run_to(m_div - 1, "to_tick");
        cycle(1'b1, 1'b1, 6, "req_at_tick");
        run(16, 1'b1, "n6_run");

        // Pending change then stop: ack in first IDLE cycle
        run_to(1, "to_cnt1b");
        cycle(1'b1, 1'b1, 3, "req3");
        run(10, 1'b0, "drain_pend");

        // Start and change on the same edge from IDLE
        cycle(1'b1, 1'b1, 4, "start_and_req");
        run(10, 1'b1, "n4b_run");

        // Stop cancelled during drain
        run_to(1, "to_cnt1c");
        run(2, 1'b0, "drain_cancel");
        run(10, 1'b1, "resume");

        // Reset with a change pending
        cycle(1'b1, 1'b1, 7, "req7");
        run(10, 1'b1, "n7b_run");
        run_to(2, "to_cnt2b");
        cycle(1'b1, 1'b1, 3, "req3_pend");
        pulse_reset("rst_mid");
        run(2, 1'b0, "post_rst_idle");
        run(16, 1'b1, "post_rst_n7");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
                  int'($urandom_range(0, 12)), "rand");
        end
        run(20, 1'b0, "final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
